// File: rtl/fwvip_wb_pkg.sv
// fwvip_wb_pkg: shared types and field layout for the Wishbone target pipe.
//   state_t      : target state machine encoding (IDLE/ACTIVE/DRAIN)
//   RSP_*_LSB    : bit positions inside a response word {dat, err}
//   REQ_SEL_LSB  : start of sel inside a request word {adr, dat_w, we, sel}
//   req_*_lsb()  : remaining request field positions, which depend on data width
package fwvip_wb_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    localparam int RSP_ERR_LSB = 0;
    localparam int RSP_DAT_LSB = 1;
    localparam int REQ_SEL_LSB = 0;
    function automatic int req_we_lsb(input int dw);
        return dw / 8;
    endfunction
    function automatic int req_dat_lsb(input int dw);
        return dw / 8 + 1;
    endfunction
    function automatic int req_adr_lsb(input int dw);
        return dw + dw / 8 + 1;
    endfunction
endpackage

// File: rtl/fwvip_wb_target_fifo.sv
// fwvip_wb_target_fifo: DEPTH-entry request FIFO with synchronous flush.
//   clock, reset_n : clock, asynchronous active-low reset
//   push, din      : write din when not full
//   pop, dout      : dout is the head entry; pop advances it when not empty
//   flush          : drops every stored entry (wins over push/pop)
//   full, empty    : occupancy flags
module fwvip_wb_target_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = wp == rp;
    assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign dout    = mem[rp[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fwvip_wb_target_pipe.sv
// fwvip_wb_target_pipe: Wishbone B4 pipelined target bridged to ready/valid request/response streams.
//   clock, reset_n            : clock, asynchronous active-low reset
//   tadr/tdat_w/tsel/tcyc/tstb/twe : Wishbone request inputs
//   tdat_r/tack/terr/tstall   : Wishbone response and flow-control outputs
//   req_dat/req_valid/req_ready : outgoing requests packed {adr, dat_w, we, sel}
//   rsp_dat/rsp_valid/rsp_ready : incoming responses packed {dat, err}
// Optional watchdog: define FWVIP_WB_TARGET_TIMEOUT_EN to terminate with terr
// a transaction whose response takes TIMEOUT_CYCLES; the late response is dropped.
module fwvip_wb_target_pipe
    import fwvip_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int REQ_WIDTH     = ADDR_WIDTH + DATA_WIDTH + 1 + DATA_WIDTH / 8,
    localparam int RSP_WIDTH     = DATA_WIDTH + 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   tadr,
    input  logic [DATA_WIDTH-1:0]   tdat_w,
    input  logic [DATA_WIDTH/8-1:0] tsel,
    input  logic                    tcyc,
    input  logic                    tstb,
    input  logic                    twe,
    output logic [DATA_WIDTH-1:0]   tdat_r,
    output logic                    tack,
    output logic                    terr,
    output logic                    tstall,
    output logic [REQ_WIDTH-1:0]    req_dat,
    output logic                    req_valid,
    input  logic                    req_ready,
    input  logic [RSP_WIDTH-1:0]    rsp_dat,
    input  logic                    rsp_valid,
    output logic                    rsp_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("fwvip_wb_target_pipe: unsupported parameter set");
    end
    state_t                state, state_n;
    logic [CW-1:0]         outstanding, issued;
    logic                  fifo_full, fifo_empty, push, pop, flush, accept;
    logic                  rsp_fire, live, drop, wd_hit, term, ack_en, rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data;
    assign rsp_err   = rsp_dat[RSP_ERR_LSB];
    assign rsp_data  = rsp_dat[RSP_DAT_LSB +: DATA_WIDTH];
    assign tstall    = outstanding == FULL_CNT || state != ACTIVE;
    assign accept    = tcyc && tstb && !tstall;
    assign push      = accept && !fifo_full;
    assign req_valid = !fifo_empty;
    assign pop       = req_valid && req_ready;
    // Leaving ACTIVE with work in flight: unsent requests are dropped here.
    assign flush     = state == ACTIVE && !tcyc && outstanding != '0;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign live      = rsp_fire && !drop;
    assign term      = tack || terr;
    // Only terminate towards a master that still holds the cycle; a response
    // landing on the cycle that leaves ACTIVE is discarded like a drained one.
    assign ack_en    = state == ACTIVE && tcyc;
    fwvip_wb_target_fifo #(
        .WIDTH(REQ_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    ({tadr, tdat_w, twe, tsel}),
        .dout   (req_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
`ifdef FWVIP_WB_TARGET_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic [CW-1:0] late;
    // Responses owed to timed-out transactions come first (in order) and are swallowed.
    assign drop      = late != '0;
    assign wd_hit    = issued != '0 && !rsp_fire && wd_cnt == WW'(TIMEOUT_CYCLES);
    assign rsp_ready = issued != '0 || drop;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            late   <= '0;
        end else begin
            wd_cnt <= (rsp_fire || issued == '0 || wd_hit) ? '0 : wd_cnt + 1'b1;
            late   <= late + CW'(wd_hit) - CW'(rsp_fire && drop);
        end
    end
`else
    assign drop      = 1'b0;
    assign wd_hit    = 1'b0;
    assign rsp_ready = issued != '0;
`endif
    always_comb begin
        state_n = state == IDLE   ? (tcyc ? ACTIVE : IDLE) :
                  state == ACTIVE ? (tcyc ? ACTIVE : (outstanding == '0 ? IDLE : DRAIN)) :
                  (issued == '0 && fifo_empty) ? IDLE : DRAIN;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            outstanding <= '0;
            issued      <= '0;
            tack        <= 1'b0;
            terr        <= 1'b0;
            tdat_r      <= '0;
        end else begin
            state       <= state_n;
            outstanding <= flush ? '0 : outstanding + CW'(accept) - CW'(term);
            issued      <= issued + CW'(pop) - CW'(live) - CW'(wd_hit);
            tack        <= live && ack_en && !rsp_err;
            terr        <= (live && ack_en && rsp_err) || (wd_hit && ack_en);
            if (live && ack_en) tdat_r <= rsp_data;
        end
    end
endmodule

// File: tb/tb_fwvip_wb_target_pipe.sv
// tb_fwvip_wb_target_pipe: directed self-checking bench for fwvip_wb_target_pipe.
// Build with FWVIP_WB_TARGET_TIMEOUT_EN defined to also exercise the watchdog.
module tb_fwvip_wb_target_pipe;
    import fwvip_wb_pkg::*;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
`ifdef FWVIP_WB_TARGET_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 256;
`endif
    localparam int REQW = AW + DW + 1 + DW / 8;
    localparam int RSPW = DW + 1;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   tadr;
    logic [DW-1:0]   tdat_w;
    logic [DW/8-1:0] tsel;
    logic            tcyc, tstb, twe;
    logic [DW-1:0]   tdat_r;
    logic            tack, terr, tstall;
    logic [REQW-1:0] req_dat;
    logic            req_valid, req_ready;
    logic [RSPW-1:0] rsp_dat;
    logic            rsp_valid, rsp_ready;

    always #5 clock = ~clock;

    fwvip_wb_target_pipe #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .tadr(tadr), .tdat_w(tdat_w), .tsel(tsel), .tcyc(tcyc), .tstb(tstb), .twe(twe),
        .tdat_r(tdat_r), .tack(tack), .terr(terr), .tstall(tstall),
        .req_dat(req_dat), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_dat(rsp_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
    );

    typedef struct {
        int            t;
        logic [AW-1:0] adr;
    } pend_t;

    pend_t           rq[$];
    logic [RSPW-1:0] sb[$];
    logic [REQW-1:0] rs[$];
    int total = 0, bad = 0, cyc = 0, term_cnt = 0, stall_cnt = 0, acc_term = 0, mode = 0;
    int tc, c0;
    bit last_acc, rsp_en;

    function automatic logic [RSPW-1:0] rsp_for(input logic [AW-1:0] adr);
        return adr == 32'h10 ? {32'hDEADBEEF, 1'b1} : {adr ^ 32'hC0DE_0000, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic            a, p, t;
        logic [RSPW-1:0] e;
        pend_t           pe;
        #1;
        a = tcyc && tstb && !tstall;
        p = req_valid && req_ready;
        t = rsp_valid && rsp_ready;
        if (tcyc && tstb && tstall) stall_cnt++;
        last_acc = a;
        if (a) begin
            acc_term = term_cnt;
            sb.push_back(rsp_for(tadr));
            rs.push_back({tadr, tdat_w, twe, tsel});
        end
        if (p) begin
            if (rs.size() == 0) chk("req_unexpected", 1, 0);
            else chk("req_dat", req_dat, rs.pop_front());
            pe.t = cyc;
            pe.adr = req_dat[req_adr_lsb(DW) +: AW];
            rq.push_back(pe);
        end
        if (t && rq.size() > 0) void'(rq.pop_front());
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (tack || terr) begin
            term_cnt++;
            if (mode == 0) begin
                if (sb.size() == 0) chk("term_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("term", {tdat_r, terr, tack}, {e, ~e[0]});
                end
            end else if (mode == 1) chk("term_none", {terr, tack}, 2'b00);
        end
        if (rsp_en && rq.size() > 0 && cyc >= rq[0].t + LAT) begin
            rsp_valid = 1'b1;
            rsp_dat = rsp_for(rq[0].adr);
        end else rsp_valid = 1'b0;
    endtask

    task automatic wb_req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] d);
        tadr = adr;
        twe = we;
        tdat_w = d;
        tsel = '1;
        tstb = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("accept", last_acc, 1);
        tstb = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 200 && (sb.size() > 0 || rq.size() > 0); i++) tick();
        chk("settle", sb.size(), 0);
    endtask

    task automatic wait_active();
        for (int i = 0; i < 8 && tstall; i++) tick();
        chk("active", tstall, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset_n = 1'b0; tcyc = 0; tstb = 0; twe = 0; tadr = '0; tdat_w = '0; tsel = '0;
        req_ready = 0; rsp_valid = 0; rsp_dat = '0; rsp_en = 1; mode = 0;
        #1;
        chk("rst_tstall", tstall, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_tack", tack, 0);
        chk("rst_terr", terr, 0);
        chk("rst_tdat_r", tdat_r, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back writes with an always-ready sink.
        req_ready = 1'b1;
        tcyc = 1'b1;
        wait_active();
        stall_cnt = 0;
        tc = term_cnt;
        for (int i = 0; i < 4; i++) wb_req(32'(i * 4), 1'b1, 32'h1000 + 32'(i));
        settle();
        chk("b2b_terms", term_cnt - tc, 4);
        chk("b2b_stall", stall_cnt, 0);

        // Fill to DEPTH with the sink stalled, then release it.
        req_ready = 1'b0;
        tc = term_cnt;
        for (int i = 0; i < 4; i++) wb_req(32'h20 + 32'(4 * i), 1'b0, '0);
        chk("full_stall", tstall, 1);
        chk("full_req_valid", req_valid, 1);
        req_ready = 1'b1;
        wb_req(32'h30, 1'b0, '0);
        chk("fifth_after_ack", acc_term > tc, 1);
        wb_req(32'h34, 1'b0, '0);
        settle();
        chk("full_terms", term_cnt - tc, 6);

        // Error response.
        wb_req(32'h10, 1'b0, '0);
        for (int i = 0; i < 40 && !terr; i++) tick();
        chk("err_terr", terr, 1);
        chk("err_tack", tack, 0);
        chk("err_tdat_r", tdat_r, 32'hDEADBEEF);
        tick();
        chk("err_pulse_end", {terr, tack}, 2'b00);
        settle();

        // Master abandons the cycle after the first response.
        tc = term_cnt;
        for (int i = 0; i < 3; i++) wb_req(32'h40 + 32'(4 * i), 1'b0, '0);
        for (int i = 0; i < 40 && term_cnt == tc; i++) tick();
        chk("drain_first", term_cnt - tc, 1);
        tcyc = 1'b0;
        mode = 1;
        tick();
        sb.delete();
        rs.delete();
        for (int i = 0; i < 40 && (rq.size() > 0 || rsp_ready); i++) tick();
        chk("drain_consumed", rq.size(), 0);
        chk("drain_rsp_ready", rsp_ready, 0);
        chk("drain_no_term", term_cnt - tc, 1);
        chk("drain_stall", tstall, 1);
        mode = 0;
        tcyc = 1'b1;
        wait_active();

        // Reset in the middle of two transactions.
        req_ready = 1'b0;
        rsp_en = 1'b0;
        wb_req(32'h50, 1'b0, '0);
        wb_req(32'h54, 1'b0, '0);
        tick();
        chk("pre_rst_valid", req_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", req_valid, 0);
        chk("mid_rst_tack", tack, 0);
        chk("mid_rst_rsp_ready", rsp_ready, 0);
        chk("mid_rst_tstall", tstall, 1);
        chk("mid_rst_tdat_r", tdat_r, 0);
        tcyc = 1'b0;
        rsp_valid = 1'b0;
        rq.delete();
        sb.delete();
        rs.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        req_ready = 1'b1;
        rsp_en = 1'b1;
        tc = term_cnt;
        mode = 1;
        repeat (10) tick();
        chk("post_rst_terms", term_cnt - tc, 0);
        chk("post_rst_req_valid", req_valid, 0);
        mode = 0;

`ifdef FWVIP_WB_TARGET_TIMEOUT_EN
        // Unanswered read: watchdog terminates it, the late answer is swallowed.
        tcyc = 1'b1;
        wait_active();
        rsp_en = 1'b0;
        mode = 2;
        wb_req(32'h60, 1'b0, '0);
        c0 = cyc;
        for (int i = 0; i < 40 && !terr; i++) tick();
        chk("tmo_terr", terr, 1);
        chk("tmo_tack", tack, 0);
        chk("tmo_delay", (cyc - c0 >= TMO) && (cyc - c0 <= TMO + 4), 1);
        sb.delete();
        mode = 1;
        rsp_en = 1'b1;
        repeat (8) tick();
        chk("tmo_late_consumed", rq.size(), 0);
        chk("tmo_rsp_ready", rsp_ready, 0);
        mode = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
